axi_pmp_cut: RTL and testbench

- Address-channel register slice (spill register / cut) with a RISC-V PMP permission check on each request.
- Every AXI address beat (AR or AW) presented at the input is checked against NR_ENTRIES PMP entries.
- The beat is stored in a 2-entry spill buffer and leaves one cycle later with its allow verdict attached.
- Sits between an untrusted DMA/IO master and the interconnect; downstream logic uses out_allow to forward or error-respond.

---
 rtl/axi_pmp_cut.sv | 139 +++++++++++++
 tb/tb_axi_pmp_cut.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/axi_pmp_cut.sv
// axi_pmp_cut: AXI address-channel cut (2-slot spill register) that tags each beat with a PMP verdict.
// Latency: 1 cycle when BYPASS=0 (outputs registered); 0 cycles when BYPASS=1 (outputs combinational).
// Backpressure: in_ready drops only when both slots hold beats; it is registered, with no path from out_ready.
// Ports: clk/rst (synchronous, active-high), in_* request side, out_* registered side plus out_allow,
//        conf_addr_i/conf_i packed pmpaddr/pmpcfg arrays, entry i at [i*PMP_LEN +: PMP_LEN] / [i*8 +: 8].
module axi_pmp_cut #(
  parameter int unsigned PLEN       = 56,
  parameter int unsigned PMP_LEN    = 54,
  parameter int unsigned NR_ENTRIES = 16,
  parameter int unsigned BYPASS     = 0
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [PLEN-1:0]                in_addr,
  input  logic                           in_write,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [PLEN-1:0]                out_addr,
  output logic                           out_write,
  output logic                           out_allow,
  input  logic [NR_ENTRIES*PMP_LEN-1:0]  conf_addr_i,
  input  logic [NR_ENTRIES*8-1:0]        conf_i
);

  localparam logic [PMP_LEN-1:0] ONE = {{(PMP_LEN-1){1'b0}}, 1'b1};

  // Word address compared against pmpaddr registers.
  logic [PMP_LEN-1:0] a_word;
  assign a_word = in_addr[PLEN-1:2];

  logic [PMP_LEN-1:0] c, lo, dont_care;
  logic [7:0]         cfg;
  logic               m, hit, allow_c;

  // Lowest-index matching entry decides; S-mode, so the L bit and X bit play no role.
  always_comb begin
    allow_c   = 1'b0;
    hit       = 1'b0;
    c         = '0;
    lo        = '0;
    dont_care = '0;
    cfg       = '0;
    m         = 1'b0;
    for (int i = 0; i < NR_ENTRIES; i++) begin
      c   = conf_addr_i[i*PMP_LEN +: PMP_LEN];
      cfg = conf_i[i*8 +: 8];
      // c ^ (c+1) sets bit k plus the k trailing ones: exactly the bits inside the NAPOT region.
      // All-ones c wraps c+1 to zero, so every bit becomes don't-care and everything matches.
      dont_care = c ^ (c + ONE);
      case (cfg[4:3])
        2'd1:    m = (lo < c) && (a_word >= lo) && (a_word < c);
        2'd2:    m = (a_word == c);
        2'd3:    m = ((a_word ^ c) & ~dont_care) == '0;
        default: m = 1'b0;
      endcase
      if (!hit && m) begin
        hit     = 1'b1;
        allow_c = in_write ? cfg[1] : cfg[0];
      end
      // TOR lower bound of the next entry is this entry's pmpaddr.
      lo = c;
    end
  end

  // Bits intentionally not consulted: byte offset of the address, X/L/reserved cfg bits.
  logic unused_cfg_bits;
  always_comb begin
    unused_cfg_bits = ^in_addr[1:0];
    for (int i = 0; i < NR_ENTRIES; i++) begin
      unused_cfg_bits = unused_cfg_bits ^ conf_i[i*8+2] ^ (^conf_i[i*8+5 +: 3]);
    end
  end

  generate
    if (BYPASS != 0) begin : g_bypass
      assign out_valid = in_valid;
      assign in_ready  = out_ready;
      assign out_addr  = in_addr;
      assign out_write = in_write;
      assign out_allow = allow_c;
    end else begin : g_cut
      // Slot a drives the outputs; slot b only fills when a is stalled.
      logic            a_vld, b_vld;
      logic [PLEN-1:0] a_addr, b_addr;
      logic            a_write, b_write, a_allow, b_allow;
      logic            push;

      assign in_ready  = ~b_vld;
      assign push      = in_valid & ~b_vld;
      assign out_valid = a_vld;
      assign out_addr  = a_addr;
      assign out_write = a_write;
      assign out_allow = a_allow;

      always_ff @(posedge clk) begin
        if (rst) begin
          a_vld   <= 1'b0;
          b_vld   <= 1'b0;
          a_addr  <= '0;
          b_addr  <= '0;
          a_write <= 1'b0;
          b_write <= 1'b0;
          a_allow <= 1'b0;
          b_allow <= 1'b0;
        end else if (a_vld && b_vld) begin
          // Full: no push possible; drain moves b forward.
          if (out_ready) begin
            a_addr  <= b_addr;
            a_write <= b_write;
            a_allow <= b_allow;
            b_vld   <= 1'b0;
          end
        end else if (a_vld) begin
          if (out_ready) begin
            a_vld <= push;
            if (push) begin
              a_addr  <= in_addr;
              a_write <= in_write;
              a_allow <= allow_c;
            end
          end else if (push) begin
            b_vld   <= 1'b1;
            b_addr  <= in_addr;
            b_write <= in_write;
            b_allow <= allow_c;
          end
        end else if (push) begin
          a_vld   <= 1'b1;
          a_addr  <= in_addr;
          a_write <= in_write;
          a_allow <= allow_c;
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_axi_pmp_cut.sv
module tb_axi_pmp_cut;
  localparam int PLEN = 56;
  localparam int PMP_LEN = 54;
  localparam int NR = 16;

  logic clk = 1'b0;
  logic rst;
  logic in_valid, in_ready, in_write, out_valid, out_ready, out_write, out_allow;
  logic [PLEN-1:0] in_addr, out_addr;
  logic b_in_valid, b_in_ready, b_in_write, b_out_valid, b_out_ready, b_out_write, b_out_allow;
  logic [PLEN-1:0] b_in_addr, b_out_addr;
  logic [NR*PMP_LEN-1:0] conf_addr;
  logic [NR*8-1:0] conf;

  int passed = 0;
  int total = 0;

  always #5 clk = ~clk;

  axi_pmp_cut #(.PLEN(PLEN), .PMP_LEN(PMP_LEN), .NR_ENTRIES(NR), .BYPASS(0)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr), .in_write(in_write),
    .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr), .out_write(out_write),
    .out_allow(out_allow), .conf_addr_i(conf_addr), .conf_i(conf)
  );

  axi_pmp_cut #(.PLEN(PLEN), .PMP_LEN(PMP_LEN), .NR_ENTRIES(NR), .BYPASS(1)) dut_byp (
    .clk(clk), .rst(rst),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_addr(b_in_addr), .in_write(b_in_write),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_addr(b_out_addr), .out_write(b_out_write),
    .out_allow(b_out_allow), .conf_addr_i(conf_addr), .conf_i(conf)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic set_entry(input int idx, input logic [PMP_LEN-1:0] a, input logic [7:0] c);
    conf_addr[idx*PMP_LEN +: PMP_LEN] = a;
    conf[idx*8 +: 8] = c;
  endtask

  // One beat through an empty slice with out_ready high; checks the beat one cycle later.
  task automatic xfer(input string tag, input logic [PLEN-1:0] addr, input logic wr, input logic exp_allow);
    in_valid = 1'b1; in_addr = addr; in_write = wr; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check({tag, ".valid"}, {63'd0, out_valid}, 64'd1);
    check({tag, ".addr"}, {8'd0, out_addr}, {8'd0, addr});
    check({tag, ".write"}, {63'd0, out_write}, {63'd0, wr});
    check({tag, ".allow"}, {63'd0, out_allow}, {63'd0, exp_allow});
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_addr = '0; in_write = 1'b0; out_ready = 1'b0;
    b_in_valid = 1'b0; b_in_addr = '0; b_in_write = 1'b0; b_out_ready = 1'b0;
    conf_addr = '0; conf = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    check("rst.out_valid", {63'd0, out_valid}, 64'd0);
    check("rst.in_ready", {63'd0, in_ready}, 64'd1);
    check("rst.out_allow", {63'd0, out_allow}, 64'd0);
    check("rst.out_addr", {8'd0, out_addr}, 64'd0);
    check("rst.out_write", {63'd0, out_write}, 64'd0);
    @(posedge clk); #1;
    check("idle.out_valid", {63'd0, out_valid}, 64'd0);

    // All entries OFF: deny
    xfer("off_rd", 56'h1000, 1'b0, 1'b0);

    // NAPOT 8 KiB at 0, R only
    set_entry(0, 54'h3FF, 8'h19);
    xfer("napot_rd_in", 56'h1FF8, 1'b0, 1'b1);
    xfer("napot_rd_out", 56'h2000, 1'b0, 1'b0);
    xfer("napot_wr", 56'h0010, 1'b1, 1'b0);

    // TOR [0x1000, 0x2000) via entry1, R/W
    set_entry(0, 54'h400, 8'h00);
    set_entry(1, 54'h800, 8'h0B);
    xfer("tor_lo", 56'h1000, 1'b1, 1'b1);
    xfer("tor_hi", 56'h1FFC, 1'b1, 1'b1);
    xfer("tor_above", 56'h2000, 1'b1, 1'b0);
    xfer("tor_below", 56'h0FFC, 1'b1, 1'b0);

    // Backpressure: 4 reads, out_ready low
    out_ready = 1'b0;
    in_valid = 1'b1; in_write = 1'b0; in_addr = 56'h1000;
    @(posedge clk); #1;
    check("bp.ready1", {63'd0, in_ready}, 64'd1);
    check("bp.valid1", {63'd0, out_valid}, 64'd1);
    in_addr = 56'h2000;
    @(posedge clk); #1;
    check("bp.ready_full", {63'd0, in_ready}, 64'd0);
    in_addr = 56'h1004;
    set_entry(1, 54'h800, 8'h00);  // config turned off while two beats held
    @(posedge clk); #1;
    check("bp.hold_addr", {8'd0, out_addr}, 64'h1000);
    check("bp.hold_allow", {63'd0, out_allow}, 64'd1);
    check("bp.hold_ready", {63'd0, in_ready}, 64'd0);
    set_entry(1, 54'h800, 8'h0B);
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp.b1_addr", {8'd0, out_addr}, 64'h2000);
    check("bp.b1_allow", {63'd0, out_allow}, 64'd0);
    check("bp.ready_again", {63'd0, in_ready}, 64'd1);
    @(posedge clk); #1;
    in_addr = 56'h0FFC;
    check("bp.b2_addr", {8'd0, out_addr}, 64'h1004);
    check("bp.b2_allow", {63'd0, out_allow}, 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("bp.b3_addr", {8'd0, out_addr}, 64'h0FFC);
    check("bp.b3_allow", {63'd0, out_allow}, 64'd0);
    check("bp.b3_valid", {63'd0, out_valid}, 64'd1);
    @(posedge clk); #1;
    check("bp.drained", {63'd0, out_valid}, 64'd0);

    // Priority: NA4 no-perm entry shadows an all-ones NAPOT
    set_entry(0, 54'h400, 8'h10);
    set_entry(1, {PMP_LEN{1'b1}}, 8'h1B);
    xfer("prio_na4", 56'h1000, 1'b0, 1'b0);
    xfer("prio_napot", 56'h1004, 1'b0, 1'b1);

    // Reset with two beats buffered
    out_ready = 1'b0;
    in_valid = 1'b1; in_addr = 56'h1004;
    @(posedge clk); #1;
    in_addr = 56'h2004;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("mrst.full", {63'd0, in_ready}, 64'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("mrst.out_valid", {63'd0, out_valid}, 64'd0);
    check("mrst.in_ready", {63'd0, in_ready}, 64'd1);
    check("mrst.out_allow", {63'd0, out_allow}, 64'd0);
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("mrst.stays_empty", {63'd0, out_valid}, 64'd0);

    // Bypass build: same-cycle pass-through
    b_in_valid = 1'b1; b_in_addr = 56'h1004; b_in_write = 1'b0; b_out_ready = 1'b0;
    #1;
    check("byp.valid", {63'd0, b_out_valid}, 64'd1);
    check("byp.ready", {63'd0, b_in_ready}, 64'd0);
    check("byp.addr", {8'd0, b_out_addr}, 64'h1004);
    check("byp.allow", {63'd0, b_out_allow}, 64'd1);
    b_in_addr = 56'h1000; b_out_ready = 1'b1;
    #1;
    check("byp.ready_hi", {63'd0, b_in_ready}, 64'd1);
    check("byp.deny", {63'd0, b_out_allow}, 64'd0);
    b_in_valid = 1'b0;
    #1;
    check("byp.valid_lo", {63'd0, b_out_valid}, 64'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
